// File: rtl/pill_line_sim.sv
// Plant-side model of the pill bottling line: hopper reservoir with timed drops and a
// conveyor that advances bottles, producing the sensor levels the bottling controller reads.
module pill_line_sim #(
    parameter int PILL_PERIOD_MS = 1000,
    parameter int PULSE_MS       = 100,
    parameter int SWITCH_MS      = 2000,
    parameter int HOPPER_CAP     = 99,
    parameter int REFILL_QTY     = 10
) (
    input  logic       clk_1khz,
    input  logic       switch_clr,
    input  logic       feed_en,
    input  logic       conv_req,
    input  logic       manual_pill,
    input  logic       refill,
    input  logic       fault_hopper_jam,
    input  logic       fault_conveyor_jam,
    output logic       hopper_level,
    output logic       pill_pulse,
    output logic       conveyor_ok,
    output logic       bottle_in_place,
    output logic [6:0] hopper_count
);

    localparam int PW = (PILL_PERIOD_MS > 1) ? $clog2(PILL_PERIOD_MS) : 1;
    localparam int UW = $clog2(PULSE_MS + 1);
    localparam int TW = $clog2(SWITCH_MS + 1);

    typedef enum logic [1:0] {
        IN_PLACE = 2'd0,
        MOVING   = 2'd1,
        JAMMED   = 2'd2
    } conv_state_t;

    conv_state_t   state_reg, state_next;
    logic [TW-1:0] travel_cnt_reg, travel_cnt_next;
    logic [PW-1:0] period_cnt_reg, period_cnt_next;
    logic [UW-1:0] pulse_cnt_reg, pulse_cnt_next;
    logic [6:0]    count_reg, count_next;
    logic          conv_prev_reg, manual_prev_reg, refill_prev_reg;
    logic          hopper_level_reg, pill_pulse_reg, conveyor_ok_reg, bip_reg;
    logic          hopper_level_next, conveyor_ok_next, bip_next;

    logic          conv_edge, manual_edge, refill_edge;
    logic          has_pills, drop_gate, auto_req, manual_req, drop_accept;
    logic [7:0]    refill_sum, refill_sat;

    // Drop path: period counter, manual request, pulse stretcher and reservoir arithmetic
    always_comb begin
        conv_edge   = conv_req & ~conv_prev_reg;
        manual_edge = manual_pill & ~manual_prev_reg;
        refill_edge = refill & ~refill_prev_reg;

        has_pills = (count_reg != 7'd0);
        drop_gate = feed_en & bip_reg & ~fault_hopper_jam & has_pills;

        period_cnt_next = '0;
        auto_req        = 1'b0;
        if (drop_gate) begin
            if (period_cnt_reg == PW'(PILL_PERIOD_MS - 1)) begin
                auto_req = 1'b1;
            end else begin
                period_cnt_next = period_cnt_reg + 1'b1;
            end
        end

        manual_req  = manual_edge & ~fault_hopper_jam & has_pills;
        // Requests during an active pulse are dropped, never queued
        drop_accept = (auto_req | manual_req) & (pulse_cnt_reg == '0);

        pulse_cnt_next = pulse_cnt_reg;
        if (drop_accept) begin
            pulse_cnt_next = UW'(PULSE_MS);
        end else if (pulse_cnt_reg != '0) begin
            pulse_cnt_next = pulse_cnt_reg - 1'b1;
        end
        hopper_level_next = (pulse_cnt_next != '0);

        refill_sum = {1'b0, count_reg} + (refill_edge ? 8'(REFILL_QTY) : 8'd0);
        refill_sat = (refill_sum > 8'(HOPPER_CAP)) ? 8'(HOPPER_CAP) : refill_sum;
        count_next = refill_sat[6:0] - {6'd0, drop_accept};
    end

    // Conveyor FSM: a jam freezes the travel count, so a J-cycle jam stretches the move by J
    always_comb begin
        state_next      = state_reg;
        travel_cnt_next = travel_cnt_reg;
        case (state_reg)
            IN_PLACE: begin
                if (conv_edge) begin
                    state_next      = MOVING;
                    travel_cnt_next = TW'(SWITCH_MS);
                end
            end
            MOVING, JAMMED: begin
                if (fault_conveyor_jam) begin
                    state_next = JAMMED;
                end else if (travel_cnt_reg == TW'(1)) begin
                    state_next      = IN_PLACE;
                    travel_cnt_next = '0;
                end else begin
                    state_next      = MOVING;
                    travel_cnt_next = travel_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next      = IN_PLACE;
                travel_cnt_next = '0;
            end
        endcase
        bip_next         = (state_next == IN_PLACE);
        conveyor_ok_next = ~((state_next == JAMMED) ||
                             ((state_next == IN_PLACE) && fault_conveyor_jam));
    end

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state_reg        <= IN_PLACE;
            travel_cnt_reg   <= '0;
            period_cnt_reg   <= '0;
            pulse_cnt_reg    <= '0;
            count_reg        <= 7'(HOPPER_CAP);
            conv_prev_reg    <= 1'b0;
            manual_prev_reg  <= 1'b0;
            refill_prev_reg  <= 1'b0;
            hopper_level_reg <= 1'b0;
            pill_pulse_reg   <= 1'b0;
            conveyor_ok_reg  <= 1'b1;
            bip_reg          <= 1'b1;
        end else begin
            state_reg        <= state_next;
            travel_cnt_reg   <= travel_cnt_next;
            period_cnt_reg   <= period_cnt_next;
            pulse_cnt_reg    <= pulse_cnt_next;
            count_reg        <= count_next;
            conv_prev_reg    <= conv_req;
            manual_prev_reg  <= manual_pill;
            refill_prev_reg  <= refill;
            hopper_level_reg <= hopper_level_next;
            pill_pulse_reg   <= drop_accept;
            conveyor_ok_reg  <= conveyor_ok_next;
            bip_reg          <= bip_next;
        end
    end

    assign hopper_level    = hopper_level_reg;
    assign pill_pulse      = pill_pulse_reg;
    assign conveyor_ok     = conveyor_ok_reg;
    assign bottle_in_place = bip_reg;
    assign hopper_count    = count_reg;

endmodule

// File: tb/tb_pill_line_sim.sv
// Directed bench for pill_line_sim: auto/manual drops, conveyor moves and jams,
// empty/refill saturation and asynchronous reset mid-operation.
module tb_pill_line_sim;

    logic       clk_1khz = 1'b0;
    logic       switch_clr;
    logic       feed_en, conv_req, manual_pill, refill;
    logic       fault_hopper_jam, fault_conveyor_jam;
    logic       hopper_level, pill_pulse, conveyor_ok, bottle_in_place;
    logic [6:0] hopper_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulses[$];
    int hl_high = 0;
    int bip_low = 0;
    int ok_low = 0;
    int t0, tc;

    pill_line_sim #(
        .PILL_PERIOD_MS(1000),
        .PULSE_MS(100),
        .SWITCH_MS(2000),
        .HOPPER_CAP(20),
        .REFILL_QTY(10)
    ) dut (
        .clk_1khz(clk_1khz),
        .switch_clr(switch_clr),
        .feed_en(feed_en),
        .conv_req(conv_req),
        .manual_pill(manual_pill),
        .refill(refill),
        .fault_hopper_jam(fault_hopper_jam),
        .fault_conveyor_jam(fault_conveyor_jam),
        .hopper_level(hopper_level),
        .pill_pulse(pill_pulse),
        .conveyor_ok(conveyor_ok),
        .bottle_in_place(bottle_in_place),
        .hopper_count(hopper_count)
    );

    always #5 clk_1khz = ~clk_1khz;

    always @(posedge clk_1khz) cyc <= cyc + 1;

    always @(negedge clk_1khz) begin
        if (pill_pulse === 1'b1) pulses.push_back(cyc);
        if (hopper_level === 1'b1) hl_high++;
        if (bottle_in_place === 1'b0) bip_low++;
        if (conveyor_ok === 1'b0) ok_low++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", tag, obs, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_1khz);
        #1;
    endtask

    task automatic manual_drop();
        manual_pill = 1'b1;
        tick(1);
        manual_pill = 1'b0;
    endtask

    initial begin
        switch_clr = 1'b1;
        feed_en = 0; conv_req = 0; manual_pill = 0; refill = 0;
        fault_hopper_jam = 0; fault_conveyor_jam = 0;
        #2 switch_clr = 1'b0;
        #1;
        check("rst_hopper_level", int'(hopper_level), 0);
        check("rst_pill_pulse", int'(pill_pulse), 0);
        check("rst_conveyor_ok", int'(conveyor_ok), 1);
        check("rst_bottle_in_place", int'(bottle_in_place), 1);
        check("rst_hopper_count", int'(hopper_count), 20);
        tick(3);
        switch_clr = 1'b1;

        // Auto drops every 1000 cycles, 100-cycle high time
        tick(1);
        t0 = cyc; feed_en = 1'b1; pulses.delete(); hl_high = 0;
        tick(3500);
        check("auto_strobe_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("auto_drop1_time", pulses[0] - t0, 1000);
            check("auto_drop2_time", pulses[1] - t0, 2000);
            check("auto_drop3_time", pulses[2] - t0, 3000);
        end
        check("auto_level_high_cycles", hl_high, 300);
        check("auto_count", int'(hopper_count), 17);
        feed_en = 1'b0;

        // Bottle advance while feeding
        tick(1);
        feed_en = 1'b1;
        tick(300);
        conv_req = 1'b1; tc = cyc; pulses.delete(); bip_low = 0;
        tick(1);
        conv_req = 1'b0;
        check("move_bip_fall", int'(bottle_in_place), 0);
        tick(2000);
        check("move_bip_rise", int'(bottle_in_place), 1);
        check("move_low_cycles", bip_low, 2000);
        check("move_no_drops", pulses.size(), 0);
        tick(999);
        check("post_move_no_early_drop", int'(pill_pulse), 0);
        tick(1);
        check("post_move_drop", int'(pill_pulse), 1);
        check("post_move_count", int'(hopper_count), 16);
        feed_en = 1'b0;

        // Jam of 500 cycles starting 800 cycles into a move
        tick(1);
        conv_req = 1'b1; tc = cyc;
        tick(1);
        conv_req = 1'b0;
        tick(799);
        fault_conveyor_jam = 1'b1; ok_low = 0;
        tick(1);
        check("jam_ok_low", int'(conveyor_ok), 0);
        tick(499);
        fault_conveyor_jam = 1'b0;
        tick(1);
        check("jam_ok_recovered", int'(conveyor_ok), 1);
        tick(1199);
        check("jam_bip_still_low", int'(bottle_in_place), 0);
        tick(1);
        check("jam_bip_rise", int'(bottle_in_place), 1);
        check("jam_ok_low_cycles", ok_low, 500);
        fault_conveyor_jam = 1'b1;
        tick(1);
        check("jam_in_place_ok", int'(conveyor_ok), 0);
        check("jam_in_place_bip", int'(bottle_in_place), 1);
        fault_conveyor_jam = 1'b0;
        tick(1);
        check("jam_in_place_release", int'(conveyor_ok), 1);

        // Manual collisions
        tick(1);
        feed_en = 1'b1;
        tick(1000);
        check("coll_auto_drop", int'(pill_pulse), 1);
        check("coll_auto_count", int'(hopper_count), 15);
        tick(49);
        manual_drop();
        check("coll_mid_pulse_ignored", int'(pill_pulse), 0);
        check("coll_mid_pulse_count", int'(hopper_count), 15);
        tick(948);
        manual_pill = 1'b1;
        tick(1);
        manual_pill = 1'b0;
        check("coll_same_cycle_strobe", int'(pill_pulse), 1);
        check("coll_same_cycle_count", int'(hopper_count), 14);
        tick(1);
        check("coll_single_strobe", int'(pill_pulse), 0);
        check("coll_single_dec", int'(hopper_count), 14);
        feed_en = 1'b0;
        tick(150);
        fault_hopper_jam = 1'b1;
        manual_drop();
        check("hopper_jam_blocks", int'(pill_pulse), 0);
        fault_hopper_jam = 1'b0;
        tick(1);
        manual_drop();
        check("manual_drop_strobe", int'(pill_pulse), 1);
        check("manual_drop_count", int'(hopper_count), 13);

        // Drain to empty, then refill
        for (int i = 0; i < 13; i++) begin
            tick(110);
            manual_drop();
        end
        check("drain_count", int'(hopper_count), 0);
        tick(110);
        pulses.delete();
        manual_drop();
        feed_en = 1'b1;
        tick(1500);
        check("empty_no_strobes", pulses.size(), 0);
        check("empty_count", int'(hopper_count), 0);
        refill = 1'b1;
        tick(1);
        refill = 1'b0;
        check("refill_from_empty", int'(hopper_count), 10);
        tick(999);
        check("refill_no_early_drop", int'(pill_pulse), 0);
        tick(1);
        check("refill_drop_resumes", int'(pill_pulse), 1);
        check("refill_drop_count", int'(hopper_count), 9);
        feed_en = 1'b0;
        tick(150);
        refill = 1'b1;
        tick(1);
        refill = 1'b0;
        check("refill_to_19", int'(hopper_count), 19);
        for (int i = 0; i < 4; i++) begin
            tick(110);
            manual_drop();
        end
        check("pre_saturate_count", int'(hopper_count), 15);
        refill = 1'b1;
        tick(1);
        refill = 1'b0;
        check("refill_saturates", int'(hopper_count), 20);
        tick(150);
        refill = 1'b1; manual_pill = 1'b1;
        tick(1);
        refill = 1'b0; manual_pill = 1'b0;
        check("refill_and_drop", int'(hopper_count), 19);

        // Asynchronous reset mid-pulse and mid-move
        tick(150);
        manual_drop();
        conv_req = 1'b1;
        tick(1);
        conv_req = 1'b0;
        tick(20);
        check("pre_rst_level", int'(hopper_level), 1);
        check("pre_rst_bip", int'(bottle_in_place), 0);
        #2 switch_clr = 1'b0;
        #1;
        check("rst_mid_level", int'(hopper_level), 0);
        check("rst_mid_bip", int'(bottle_in_place), 1);
        check("rst_mid_count", int'(hopper_count), 20);
        check("rst_mid_ok", int'(conveyor_ok), 1);
        tick(2);
        switch_clr = 1'b1;
        pulses.delete();
        tick(2500);
        check("post_rst_no_drops", pulses.size(), 0);
        check("post_rst_bip", int'(bottle_in_place), 1);
        check("post_rst_count", int'(hopper_count), 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
